// File: rtl/imem_pkg.sv
// Shared types and helpers for the lane-writable instruction memory.
// Lane geometry is computed here so storage and test code agree on it.
package imem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Number of write lanes covering a word; the top lane may be narrower.
  function automatic int calc_nl(input int width, input int lane_w);
    return (width + lane_w - 1) / lane_w;
  endfunction

  // True when word bit bit_idx is governed by write-enable lane `lane`.
  function automatic logic lane_hit(input int bit_idx, input int lane, input int lane_w);
    return ((bit_idx / lane_w) == lane);
  endfunction

endpackage

// File: rtl/imem_clr_seq.sv
// Clear sequencer: walks clr_addr across the array after reset or clear_req.
//   state | meaning
//   IDLE  | accesses allowed, waiting for clear_req
//   CLEAR | zeroing one word per cycle, accesses ignored
module imem_clr_seq
  import imem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state, state_nx;
  logic [AW-1:0] addr_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= addr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = clr_addr;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx = CLEAR;
          addr_nx  = '0;
        end
      end
      CLEAR: begin
        if (clr_addr == LAST) begin
          state_nx = IDLE;
          addr_nx  = '0;
        end else begin
          addr_nx = clr_addr + 1'b1;
        end
      end
      default: begin
        state_nx = CLEAR;
        addr_nx  = '0;
      end
    endcase
  end

  assign busy   = (state == CLEAR);
  // Holding reset freezes the sweep at word 0 without touching the array.
  assign clr_we = busy & ~reset;

endmodule

// File: rtl/imem_lanes.sv
// Single-port instruction memory with per-lane write enables, registered
// read data, out-of-range detection and a full-array clear sequence.
module imem_lanes
  import imem_pkg::*;
#(
  parameter int WIDTH  = 28,
  parameter int DEPTH  = 2048,
  parameter int AW     = 11,
  parameter int LANE_W = 16,
  localparam int NL    = calc_nl(WIDTH, LANE_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic [NL-1:0]    wen,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] d,
  input  logic             clear_req,
  output logic [WIDTH-1:0] q,
  output logic             rvalid,
  output logic             busy,
  output logic             addr_err
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [WIDTH-1:0] lane_mask;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             accept, is_read, in_range;

  imem_clr_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // clear_req wins over a same-cycle access; busy blocks everything.
  assign accept   = cs & ~clear_req & ~busy & ~reset;
  assign is_read  = (wen == '0);
  assign in_range = ({1'b0, address} < DEPTH_W);

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int l = 0; l < NL; l++) begin
        if (wen[l] && lane_hit(b, l, LANE_W)) lane_mask[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_addr] <= '0;
    end else if (accept && !is_read && in_range) begin
      ram[address] <= (ram[address] & ~lane_mask) | (d & lane_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rvalid   <= accept & is_read;
      addr_err <= accept & ~in_range;
      if (accept && is_read) q <= in_range ? ram[address] : '0;
    end
  end

endmodule

// File: doc/imem_lanes.md
IMEM_LANES -- requirements
Module: imem_lanes

Interface
REQ-001 SHALL provide parameter WIDTH, default 28: instruction word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 2048: number of words; any value >= 2, power of two not required.
REQ-003 SHALL provide parameter AW, default 11: address width, with 2**AW >= DEPTH.
REQ-004 SHALL provide parameter LANE_W, default 16: write-lane width; NL = ceil(WIDTH/LANE_W) lanes; lane i = bits [min((i+1)*LANE_W,WIDTH)-1 : i*LANE_W].
REQ-005 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cs, input, 1: access select.
REQ-008 SHALL have port wen, input, NL: per-lane write enable; all zero with cs means read.
REQ-009 SHALL have port address, input, AW: word address.
REQ-010 SHALL have port d, input, WIDTH: write data.
REQ-011 SHALL have port clear_req, input, 1: one-cycle request to zero the whole array.
REQ-012 SHALL have port q, output, WIDTH: registered read data.
REQ-013 SHALL have port rvalid, output, 1: one-cycle pulse, q updated this cycle.
REQ-014 SHALL have port busy, output, 1: clear sequence in progress; accesses ignored.
REQ-015 SHALL have port addr_err, output, 1: one-cycle pulse for accepted access with address >= DEPTH.

Function
REQ-016 SHALL implement FSM states IDLE and CLEAR; busy = (state==CLEAR), registered.
REQ-017 SHALL, in CLEAR, write 0 to ram[clr_addr] each cycle and increment clr_addr; after writing DEPTH-1, go to IDLE; busy high exactly DEPTH cycles.
REQ-018 SHALL, in IDLE with clear_req=1, enter CLEAR with clr_addr=0; clear_req has priority over cs in the same cycle; the access is dropped.
REQ-019 SHALL ignore clear_req and cs/wen while busy; no rvalid, no addr_err, no array write.
REQ-020 SHALL accept an access in IDLE when cs=1 and clear_req=0.
REQ-021 SHALL on accepted write (wen!=0, address<DEPTH) update only lanes with wen[i]=1; other lanes keep stored bits; no combinational read-back path.
REQ-022 SHALL on accepted read (wen==0, address<DEPTH) load q with ram[address] at the edge; rvalid=1 the following cycle; read latency 1.
REQ-023 SHALL on accepted access with address>=DEPTH perform no write; for reads load q=0 and pulse rvalid; pulse addr_err in both cases.
REQ-024 SHALL hold q unchanged on all cycles without an accepted read; rvalid and addr_err low otherwise.
REQ-025 SHALL return newly written data on a read of the same address in the following cycle; both are single-port, no same-cycle conflict exists.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=CLEAR, clr_addr=0, q=0, rvalid=0, addr_err=0; busy reads 1 from the next cycle.
REQ-027 SHALL restart clearing at address 0 when reset asserts mid-CLEAR; already-cleared words stay 0.
REQ-028 SHALL hold state at CLEAR, clr_addr at 0, and perform no array write while reset stays high.

Structure
REQ-029 SHALL place state enum, NL computation function and lane-mask function in shared package imem_pkg.
REQ-030 SHALL isolate clear sequencing (FSM, clr_addr counter, busy) in sub-module imem_clr_seq; storage and lane muxing stay in imem_lanes.

Verification
REQ-031 Reset 1 cycle, then idle -> busy high exactly 2048 cycles; read of addr 5 after busy falls -> q=0, rvalid pulse.
REQ-032 Write addr 3 d=0xABCDEF1 wen=11; write d=0x0000000 wen=01; read 3 -> q=0xABC0000.
REQ-033 DEPTH=1000, AW=10: write addr 1000 -> addr_err pulse, no write; read addr 1000 -> q=0, rvalid=1, addr_err=1.
REQ-034 clear_req with cs=1 write addr 7 same cycle -> write dropped, busy for DEPTH cycles, read 7 -> 0.
REQ-035 Reset at clear cycle 500 -> busy high another full DEPTH cycles; cs reads during busy -> no rvalid.
